// File: rtl/hbridge_deadtime_drv.sv
// hbridge_deadtime_drv
//   Output stage of the delta-sigma modulator. Registers the ternary modulator
//   code and drives the four H-bridge gates. Every level change passes through
//   an all-off dead interval of DEAD_CYC cycles, and an ON level is held for at
//   least MIN_ON cycles before it may be left. Adds fault shutdown with a latched
//   fault flag, sticky illegal-code detection and a saturating count of ON
//   entries.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   pwm_i[1:0]        code: 00 zero, 01 positive, 10 negative, 11 illegal
//   enable_i          bridge enable, low forces OFF
//   fault_i           synchronous level-sensitive fault
//   fault_clr_i       clears the latched fault (only while fault_i is low)
//   hs_a_o, ls_a_o    leg A high/low-side gates
//   hs_b_o, ls_b_o    leg B high/low-side gates
//   state_o[1:0]      0 OFF, 1 DEAD, 2 ON, 3 FAULT
//   level_o[1:0]      level driven while ON, 00 otherwise
//   fault_o           latched fault
//   illegal_o         sticky: code 11 seen since reset
//   trans_cnt_o       saturating count of ON entries
module hbridge_deadtime_drv #(
  parameter int DEAD_CYC = 3,
  parameter int MIN_ON   = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       pwm_i,
  input  logic             enable_i,
  input  logic             fault_i,
  input  logic             fault_clr_i,
  output logic             hs_a_o,
  output logic             ls_a_o,
  output logic             hs_b_o,
  output logic             ls_b_o,
  output logic [1:0]       state_o,
  output logic [1:0]       level_o,
  output logic             fault_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] trans_cnt_o
);

  localparam int DW = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam int OW = (MIN_ON < 1) ? 1 : $clog2(MIN_ON + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC);
  localparam logic [OW-1:0] ON_MIN    = OW'(MIN_ON);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DEAD  = 2'd1,
    S_ON    = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  typedef struct packed {
    logic hs_a;
    logic ls_a;
    logic hs_b;
    logic ls_b;
  } gates_t;

  state_t           state_q, state_d;
  logic [1:0]       cmd_q;
  // Target level while DEAD, driven level while ON.
  logic [1:0]       lvl_q, lvl_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [OW-1:0]    ocnt_q, ocnt_d;
  logic [CNT_W-1:0] cnt_d;
  logic             fault_d;
  gates_t           gates_d;

  // Gates are derived from the next state so they leave the register on the
  // same edge as the state, keeping every output registered.
  function automatic gates_t gate_map(input state_t s, input logic [1:0] l);
    gates_t g;
    g = '0;
    if (s == S_ON) begin
      case (l)
        2'b00:   begin g.ls_a = 1'b1; g.ls_b = 1'b1; end
        2'b01:   begin g.hs_a = 1'b1; g.ls_b = 1'b1; end
        2'b10:   begin g.hs_b = 1'b1; g.ls_a = 1'b1; end
        default: g = '0;
      endcase
    end
    return g;
  endfunction

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    dcnt_d  = dcnt_q;
    ocnt_d  = ocnt_q;
    cnt_d   = trans_cnt_o;
    fault_d = fault_o;
    if (fault_i) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
    end else if (state_q == S_FAULT) begin
      if (fault_clr_i) begin
        state_d = S_OFF;
        fault_d = 1'b0;
      end
    end else if (!enable_i) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_DEAD;
          lvl_d   = cmd_q;
          dcnt_d  = DW'(1);
        end
        S_DEAD: begin
          if (dcnt_q >= DEAD_LAST) begin
            state_d = S_ON;
            ocnt_d  = OW'(1);
            if (trans_cnt_o != {CNT_W{1'b1}}) cnt_d = trans_cnt_o + 1'b1;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        S_ON: begin
          // Only the code present at the decision edge is taken; anything
          // that came and went during MIN_ON is dropped.
          if (ocnt_q >= ON_MIN && cmd_q != lvl_q) begin
            state_d = S_DEAD;
            lvl_d   = cmd_q;
            dcnt_d  = DW'(1);
          end else if (ocnt_q < ON_MIN) begin
            ocnt_d = ocnt_q + 1'b1;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    gates_d = gate_map(state_d, lvl_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_OFF;
      cmd_q       <= 2'b00;
      lvl_q       <= 2'b00;
      dcnt_q      <= '0;
      ocnt_q      <= '0;
      trans_cnt_o <= '0;
      fault_o     <= 1'b0;
      illegal_o   <= 1'b0;
      level_o     <= 2'b00;
      hs_a_o      <= 1'b0;
      ls_a_o      <= 1'b0;
      hs_b_o      <= 1'b0;
      ls_b_o      <= 1'b0;
    end else begin
      // Illegal code is neutralised to zero before it can reach the FSM.
      cmd_q       <= (&pwm_i) ? 2'b00 : pwm_i;
      illegal_o   <= illegal_o | (&pwm_i);
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      dcnt_q      <= dcnt_d;
      ocnt_q      <= ocnt_d;
      trans_cnt_o <= cnt_d;
      fault_o     <= fault_d;
      level_o     <= (state_d == S_ON) ? lvl_d : 2'b00;
      hs_a_o      <= gates_d.hs_a;
      ls_a_o      <= gates_d.ls_a;
      hs_b_o      <= gates_d.hs_b;
      ls_b_o      <= gates_d.ls_b;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_hbridge_deadtime_drv.sv
// Bench for hbridge_deadtime_drv: directed scenarios with literal expectations
// followed by randomized stimulus, all checked every cycle against a
// transaction-level model of the bridge.
module tb_hbridge_deadtime_drv;
  localparam int DEAD_CYC = 3;
  localparam int MIN_ON   = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset, enable_i, fault_i, fault_clr_i;
  logic [1:0]       pwm_i;
  logic             hs_a_o, ls_a_o, hs_b_o, ls_b_o;
  logic [1:0]       state_o, level_o;
  logic             fault_o, illegal_o;
  logic [CNT_W-1:0] trans_cnt_o;

  hbridge_deadtime_drv #(.DEAD_CYC(DEAD_CYC), .MIN_ON(MIN_ON), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .pwm_i(pwm_i), .enable_i(enable_i),
    .fault_i(fault_i), .fault_clr_i(fault_clr_i),
    .hs_a_o(hs_a_o), .ls_a_o(ls_a_o), .hs_b_o(hs_b_o), .ls_b_o(ls_b_o),
    .state_o(state_o), .level_o(level_o), .fault_o(fault_o),
    .illegal_o(illegal_o), .trans_cnt_o(trans_cnt_o)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  wire [3:0] gates = {hs_a_o, ls_a_o, hs_b_o, ls_b_o};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state as a name, time-in-state as one counter, level as a code.
  typedef struct {
    int st;     // 0 OFF, 1 DEAD, 2 ON, 3 FAULT
    int lvl;    // target or driven level
    int since;  // cycles spent in the current state
    int cmd;    // last registered code
    int trans;
    int flt;
    int ill;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 0, 0, 0};

  function automatic mdl_t mstep(mdl_t c, logic rst, logic [1:0] pwm, logic en,
                                 logic flt, logic clr);
    mdl_t n;
    int   ns, nl;
    if (rst) return '{0, 0, 0, 0, 0, 0, 0};
    n     = c;
    n.cmd = (pwm == 2'b11) ? 0 : int'(pwm);
    if (pwm == 2'b11) n.ill = 1;
    ns = c.st;
    nl = c.lvl;
    if (flt) begin
      ns = 3; n.flt = 1;
    end else if (c.st == 3) begin
      if (clr) begin ns = 0; n.flt = 0; end
    end else if (!en) begin
      ns = 0;
    end else if (c.st == 0) begin
      ns = 1; nl = c.cmd;
    end else if (c.st == 1) begin
      if (c.since >= DEAD_CYC) begin
        ns = 2;
        n.trans = (c.trans < CNT_MAX) ? c.trans + 1 : CNT_MAX;
      end
    end else if (c.since >= MIN_ON && c.cmd != c.lvl) begin
      ns = 1; nl = c.cmd;
    end
    n.since = (ns != c.st) ? 1 : c.since + 1;
    n.st    = ns;
    n.lvl   = nl;
    return n;
  endfunction

  function automatic logic [3:0] exp_gates(int st, int lvl);
    if (st != 2) return 4'b0000;
    case (lvl)
      0:       return 4'b0101;
      1:       return 4'b1001;
      2:       return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge clock) m <= mstep(m, reset, pwm_i, enable_i, fault_i, fault_clr_i);

  // Every-cycle comparison plus structural invariants on the gates.
  int prev_st = 0, on_run = 0, dead_run = 0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("state", state_o, m.st);
      check("gates", gates, exp_gates(m.st, m.lvl));
      check("level", level_o, (m.st == 2) ? m.lvl : 0);
      check("fault_o", fault_o, m.flt);
      check("illegal_o", illegal_o, m.ill);
      check("trans_cnt", trans_cnt_o, m.trans);
      check("no_shoot_through", (hs_a_o & ls_a_o) | (hs_b_o & ls_b_o), 0);
      check("one_level_only", (gates == 4'b0000 || gates == 4'b0101 ||
                               gates == 4'b1001 || gates == 4'b0110), 1);
      if (prev_st == 2 && state_o == 2'd1) check("min_on_run", on_run >= MIN_ON, 1);
      if (prev_st == 1 && state_o == 2'd2) check("dead_run", dead_run, DEAD_CYC);
      on_run   = (state_o == 2'd2) ? ((prev_st == 2) ? on_run + 1 : 1) : 0;
      dead_run = (state_o == 2'd1) ? ((prev_st == 1) ? dead_run + 1 : 1) : 0;
      prev_st  = int'(state_o);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable_i = 1'b0; pwm_i = 2'b01; fault_i = 1'b0; fault_clr_i = 1'b0;
    step(3);
    chk_en = 1'b1;
    check("rst_state", state_o, 0);
    check("rst_gates", gates, 0);
    check("rst_trans", trans_cnt_o, 0);
    check("rst_illegal", illegal_o, 0);

    // 1: enable with 01 already registered -> 3 DEAD cycles then ON(01)
    reset = 1'b0;
    step(1);
    check("t1_off", state_o, 0);
    enable_i = 1'b1;
    for (int i = 0; i < DEAD_CYC; i++) begin
      step(1);
      check("t1_dead", state_o, 1);
      check("t1_dead_gates", gates, 0);
    end
    step(1);
    check("t1_on", state_o, 2);
    check("t1_gates", gates, 4'b1001);
    check("t1_trans", trans_cnt_o, 1);
    check("t1_level", level_o, 1);
    step(2);

    // 4: one cycle of 11 while ON(01) -> sticky flag, detour to ON(00)
    pwm_i = 2'b11;
    step(1);
    check("t4_illegal", illegal_o, 1);
    check("t4_still_on", state_o, 2);
    pwm_i = 2'b01;
    step(1);
    check("t4_dead", state_o, 1);
    step(3);
    check("t4_on00", state_o, 2);
    check("t4_level00", level_o, 0);
    check("t4_gates00", gates, 4'b0101);
    check("t4_trans", trans_cnt_o, 2);
    check("t4_illegal_hold", illegal_o, 1);
    step(5);
    check("t4_back_01", level_o, 1);
    check("t4_trans3", trans_cnt_o, 3);
    step(2);

    // 2: ON(01) -> 10 with exactly DEAD_CYC off cycles in between
    pwm_i = 2'b10;
    step(1);
    check("t2_hold", gates, 4'b1001);
    for (int i = 0; i < DEAD_CYC; i++) begin
      step(1);
      check("t2_gap", gates, 0);
    end
    step(1);
    check("t2_gates", gates, 4'b0110);
    check("t2_trans", trans_cnt_o, 4);
    step(2);

    // 5: fault in ON, clear ignored while fault high, then fault in DEAD
    fault_i = 1'b1;
    step(1);
    check("t5_fault_state", state_o, 3);
    check("t5_fault_gates", gates, 0);
    check("t5_fault_o", fault_o, 1);
    fault_clr_i = 1'b1;
    step(1);
    check("t5_clr_ignored", state_o, 3);
    fault_i = 1'b0;
    step(1);
    check("t5_cleared", state_o, 0);
    check("t5_fault_o_clr", fault_o, 0);
    fault_clr_i = 1'b0;
    step(2);
    check("t5_dead", state_o, 1);
    fault_i = 1'b1;
    step(1);
    check("t5_fault_dead", state_o, 3);
    fault_i = 1'b0; fault_clr_i = 1'b1;
    step(1);
    fault_clr_i = 1'b0;
    step(5);
    check("t5_recover", state_o, 2);
    check("t5_level", level_o, 2);

    // 3: code toggles every cycle; model and run-length checks cover it
    for (int i = 0; i < 40; i++) begin
      pwm_i = (i % 2) ? 2'b01 : 2'b00;
      step(1);
    end

    // 6: drive well past counter saturation
    for (int i = 0; i < 20; i++) begin
      pwm_i = (i % 2) ? 2'b01 : 2'b10;
      step(8);
    end
    check("t6_saturated", trans_cnt_o, CNT_MAX);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) pwm_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0 && pwm_i != 2'b11) pwm_i = 2'b11;
      enable_i    = ($urandom_range(0, 49) != 0);
      fault_i     = ($urandom_range(0, 79) == 0);
      fault_clr_i = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      step(1);
    end

    reset = 1'b0; fault_i = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
